// File: rtl/reset_sequencer_pkg.sv
// reset_seq_pkg
// Shared definitions for the reset sequencer: the 2-bit FSM state type and
// its encoding (ASSERT=0, HOLD=1, RELEASE=2, RUN=3), which is also the value
// presented on the sequencer's 'state' output.
package reset_seq_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_ASSERT  = 2'd0,
      ST_HOLD    = 2'd1,
      ST_RELEASE = 2'd2,
      ST_RUN     = 2'd3
   } state_t;

endpackage

// File: rtl/reset_sequencer_if.sv
// reset_sequencer_if
// Bundles the sequencer's control/status signals.
//   soft_rst      : synchronous soft reset request, active-high
//   domain_rst_n  : per-domain reset, active-low, bit 0 released first
//   ready         : high only while the sequencer is in RUN
//   run_cycles    : saturating count of rising edges spent in RUN
//   state         : current FSM state
// Modports: master = the sequencer, slave = the consumer of the resets.
interface reset_sequencer_if #(
   parameter int NUM_DOMAINS = 3,
   parameter int CNT_W       = 32
);
   import reset_seq_pkg::*;

   logic                   soft_rst;
   logic [NUM_DOMAINS-1:0] domain_rst_n;
   logic                   ready;
   logic [CNT_W-1:0]       run_cycles;
   state_t                 state;

   modport master (
      input  soft_rst,
      output domain_rst_n, ready, run_cycles, state
   );

   modport slave (
      output soft_rst,
      input  domain_rst_n, ready, run_cycles, state
   );

endinterface

// File: rtl/reset_sequencer_sync.sv
// reset_sync
// Asynchronous-assert / synchronous-deassert reset synchroniser.
//   clk      : clock
//   rst_n    : raw board reset, active-low, asynchronous
//   rst_sync : high once rst_n has been high for SYNC_STAGES rising edges;
//              drops immediately (no clock) when rst_n goes low
module reset_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   output logic rst_sync
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;

   // Constant 1 is shifted in at the bottom of the chain.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], 1'b1};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign rst_sync = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer
// Power-on / soft reset controller. Synchronises deassertion of the board
// reset, holds for HOLD_CYCLES edges, then releases NUM_DOMAINS reset domains
// in order, STAGE_GAP edges apart, and finally raises ready and counts run
// cycles (saturating).
//   clk  : clock, rising edge
//   rst  : board reset, active-low, asynchronous; overrides everything
//   bus  : reset_sequencer_if master modport (soft_rst in; domain_rst_n,
//          ready, run_cycles, state out). All outputs are registered.
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int NUM_DOMAINS = 3,
   parameter int HOLD_CYCLES = 4,
   parameter int STAGE_GAP   = 2,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 32
) (
   input  logic              clk,
   input  logic              rst,
   reset_sequencer_if.master bus
);

   localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
   localparam int GAP_W  = $clog2(STAGE_GAP + 1);
   localparam int IDX_W  = $clog2(NUM_DOMAINS + 1);

   localparam logic [HOLD_W-1:0]      HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [GAP_W-1:0]       GAP_LAST  = GAP_W'(STAGE_GAP - 1);
   localparam logic [IDX_W-1:0]       IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);
   localparam logic [IDX_W-1:0]       IDX_ONE   = IDX_W'(1);
   localparam logic [NUM_DOMAINS-1:0] DOM_FIRST = NUM_DOMAINS'(1);

   logic rst_sync;

   reset_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_reset_sync (
      .clk      (clk),
      .rst_n    (rst),
      .rst_sync (rst_sync)
   );

   state_t                 state_q, state_d;
   logic [HOLD_W-1:0]      hold_q,  hold_d;
   logic [GAP_W-1:0]       gap_q,   gap_d;
   // idx_q = number of domains already released = index of the next one.
   logic [IDX_W-1:0]       idx_q,   idx_d;
   logic [NUM_DOMAINS-1:0] dom_q,   dom_d;
   logic                   ready_q, ready_d;
   logic [CNT_W-1:0]       run_q,   run_d;

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      gap_d   = gap_q;
      idx_d   = idx_q;
      dom_d   = dom_q;
      ready_d = ready_q;
      run_d   = run_q;

      // Soft reset takes priority over any release scheduled on this edge.
      if (state_q != ST_ASSERT && bus.soft_rst) begin
         state_d = ST_HOLD;
         hold_d  = '0;
         gap_d   = '0;
         idx_d   = '0;
         dom_d   = '0;
         ready_d = 1'b0;
         run_d   = '0;
      end else begin
         case (state_q)
            ST_ASSERT: begin
               if (rst_sync) begin
                  state_d = ST_HOLD;
                  hold_d  = '0;
               end
            end
            ST_HOLD: begin
               if (hold_q == HOLD_LAST) begin
                  dom_d = DOM_FIRST;
                  idx_d = IDX_ONE;
                  gap_d = '0;
                  if (NUM_DOMAINS > 1) begin
                     state_d = ST_RELEASE;
                  end else begin
                     state_d = ST_RUN;
                     ready_d = 1'b1;
                  end
               end else begin
                  hold_d = hold_q + 1'b1;
               end
            end
            ST_RELEASE: begin
               if (gap_q == GAP_LAST) begin
                  gap_d = '0;
                  // Thermometer growth: releases stay contiguous from bit 0.
                  dom_d = (dom_q << 1) | DOM_FIRST;
                  idx_d = idx_q + 1'b1;
                  if (idx_q == IDX_LAST) begin
                     state_d = ST_RUN;
                     ready_d = 1'b1;
                  end
               end else begin
                  gap_d = gap_q + 1'b1;
               end
            end
            ST_RUN: begin
               if (run_q != '1) begin
                  run_d = run_q + 1'b1;
               end
            end
            default: begin
               state_d = ST_ASSERT;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_ASSERT;
         hold_q  <= '0;
         gap_q   <= '0;
         idx_q   <= '0;
         dom_q   <= '0;
         ready_q <= 1'b0;
         run_q   <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         gap_q   <= gap_d;
         idx_q   <= idx_d;
         dom_q   <= dom_d;
         ready_q <= ready_d;
         run_q   <= run_d;
      end
   end

   assign bus.domain_rst_n = dom_q;
   assign bus.ready        = ready_q;
   assign bus.run_cycles   = run_q;
   assign bus.state        = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer
// Scoreboard bench for reset_sequencer. Two instances share clk/rst:
//   dut_a : defaults (3 domains, hold 4, gap 2, sync 2, 32-bit counter)
//   dut_b : 1 domain, hold 1, 3-bit counter (saturation case)
// Stimulus pushes hand-computed expectations tagged with the rising-edge
// count at which they apply; the monitor samples on falling edges and pops
// and compares every entry due at the current edge count.
module tb_reset_sequencer;
   import reset_seq_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   reset_sequencer_if #(.NUM_DOMAINS(3), .CNT_W(32)) bus_a ();
   reset_sequencer_if #(.NUM_DOMAINS(1), .CNT_W(3))  bus_b ();

   reset_sequencer #(
      .NUM_DOMAINS (3),
      .HOLD_CYCLES (4),
      .STAGE_GAP   (2),
      .SYNC_STAGES (2),
      .CNT_W       (32)
   ) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   reset_sequencer #(
      .NUM_DOMAINS (1),
      .HOLD_CYCLES (1),
      .STAGE_GAP   (2),
      .SYNC_STAGES (2),
      .CNT_W       (3)
   ) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   typedef struct {
      int          cyc;
      logic [2:0]  dom;
      logic        rdy;
      logic [1:0]  st;
      logic [31:0] run;
      string       name;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];

   int cyc    = 0;
   int checks = 0;
   int errors = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void exp_a(int c, logic [2:0] d, logic r, logic [1:0] s,
                                 logic [31:0] n, string nm);
      exp_t e;
      e.cyc = c; e.dom = d; e.rdy = r; e.st = s; e.run = n; e.name = nm;
      q_a.push_back(e);
   endfunction

   function automatic void exp_b(int c, logic [2:0] d, logic r, logic [1:0] s,
                                 logic [31:0] n, string nm);
      exp_t e;
      e.cyc = c; e.dom = d; e.rdy = r; e.st = s; e.run = n; e.name = nm;
      q_b.push_back(e);
   endfunction

   // Monitor: compare every expectation due at this edge count.
   initial begin
      exp_t        e;
      logic [2:0]  gd;
      logic [1:0]  gs;
      logic [31:0] gr;
      forever begin
         @(negedge clk);
         while (q_a.size() > 0 && q_a[0].cyc <= cyc) begin
            e  = q_a.pop_front();
            gd = bus_a.domain_rst_n;
            gs = bus_a.state;
            gr = bus_a.run_cycles;
            checks++;
            if (e.cyc != cyc || gd !== e.dom || bus_a.ready !== e.rdy ||
                gs !== e.st || gr !== e.run) begin
               errors++;
               $display("FAIL a.%s edge=%0d(due %0d) got dom=%b rdy=%b st=%0d run=%0d want dom=%b rdy=%b st=%0d run=%0d",
                        e.name, cyc, e.cyc, gd, bus_a.ready, gs, gr, e.dom, e.rdy, e.st, e.run);
            end else begin
               $display("ok   a.%s edge=%0d dom=%b rdy=%b st=%0d run=%0d",
                        e.name, cyc, gd, bus_a.ready, gs, gr);
            end
         end
         while (q_b.size() > 0 && q_b[0].cyc <= cyc) begin
            e  = q_b.pop_front();
            gd = 3'(bus_b.domain_rst_n);
            gs = bus_b.state;
            gr = 32'(bus_b.run_cycles);
            checks++;
            if (e.cyc != cyc || gd !== e.dom || bus_b.ready !== e.rdy ||
                gs !== e.st || gr !== e.run) begin
               errors++;
               $display("FAIL b.%s edge=%0d(due %0d) got dom=%b rdy=%b st=%0d run=%0d want dom=%b rdy=%b st=%0d run=%0d",
                        e.name, cyc, e.cyc, gd, bus_b.ready, gs, gr, e.dom, e.rdy, e.st, e.run);
            end else begin
               $display("ok   b.%s edge=%0d dom=%b rdy=%b st=%0d run=%0d",
                        e.name, cyc, gd, bus_b.ready, gs, gr);
            end
         end
      end
   end

   // Called on a falling edge; returns on the falling edge where cyc == t.
   task automatic wait_to(int t);
      while (cyc < t) @(negedge clk);
   endtask

   // rst low for two edges, then high; base is the edge count such that
   // edge n of the new sequence is cyc == base + n.
   task automatic power_on(output int base);
      @(negedge clk);
      rst = 1'b0;
      exp_a(cyc + 1, 3'b000, 1'b0, 2'd0, 0, "in_reset");
      exp_b(cyc + 1, 3'b000, 1'b0, 2'd0, 0, "in_reset");
      repeat (2) @(negedge clk);
      rst = 1'b1;
      base = cyc;
   endtask

   initial begin
      int b, b3, b4, b5;
      bus_a.soft_rst = 1'b0;
      bus_b.soft_rst = 1'b0;

      // Default power-on sequence, plus the single-domain saturating instance.
      power_on(b);
      exp_a(b + 2,  3'b000, 1'b0, 2'd0, 0, "sync_wait");
      exp_a(b + 3,  3'b000, 1'b0, 2'd1, 0, "hold_entry");
      exp_a(b + 6,  3'b000, 1'b0, 2'd1, 0, "hold_last");
      exp_a(b + 7,  3'b001, 1'b0, 2'd2, 0, "rel_d0");
      exp_a(b + 8,  3'b001, 1'b0, 2'd2, 0, "gap");
      exp_a(b + 9,  3'b011, 1'b0, 2'd2, 0, "rel_d1");
      exp_a(b + 10, 3'b011, 1'b0, 2'd2, 0, "gap2");
      exp_a(b + 11, 3'b111, 1'b1, 2'd3, 0, "run_entry");
      exp_a(b + 12, 3'b111, 1'b1, 2'd3, 1, "run_1");
      exp_a(b + 16, 3'b111, 1'b1, 2'd3, 5, "run_5");
      exp_b(b + 3,  3'b000, 1'b0, 2'd1, 0, "hold_entry");
      exp_b(b + 4,  3'b001, 1'b1, 2'd3, 0, "run_entry");
      exp_b(b + 10, 3'b001, 1'b1, 2'd3, 6, "run_6");
      exp_b(b + 11, 3'b001, 1'b1, 2'd3, 7, "run_sat");
      exp_b(b + 25, 3'b001, 1'b1, 2'd3, 7, "run_sat_hold");

      // soft_rst pulse sampled on edge 20 while in RUN.
      exp_a(b + 19, 3'b111, 1'b1, 2'd3, 8, "pre_soft");
      exp_a(b + 20, 3'b000, 1'b0, 2'd1, 0, "soft_clear");
      exp_a(b + 23, 3'b000, 1'b0, 2'd1, 0, "soft_hold");
      exp_a(b + 24, 3'b001, 1'b0, 2'd2, 0, "soft_rel_d0");
      exp_a(b + 26, 3'b011, 1'b0, 2'd2, 0, "soft_rel_d1");
      exp_a(b + 28, 3'b111, 1'b1, 2'd3, 0, "soft_run");
      exp_a(b + 29, 3'b111, 1'b1, 2'd3, 1, "soft_run_1");
      wait_to(b + 19);
      bus_a.soft_rst = 1'b1;
      @(negedge clk);
      bus_a.soft_rst = 1'b0;
      wait_to(b + 30);

      // soft_rst on the same edge as domain 1's release.
      power_on(b3);
      exp_a(b3 + 8,  3'b001, 1'b0, 2'd2, 0, "pre_collide");
      exp_a(b3 + 9,  3'b000, 1'b0, 2'd1, 0, "soft_wins");
      exp_a(b3 + 10, 3'b000, 1'b0, 2'd1, 0, "no_d1_a");
      exp_a(b3 + 11, 3'b000, 1'b0, 2'd1, 0, "no_d1_b");
      exp_a(b3 + 12, 3'b000, 1'b0, 2'd1, 0, "no_d1_c");
      exp_a(b3 + 13, 3'b001, 1'b0, 2'd2, 0, "re_rel_d0");
      exp_a(b3 + 17, 3'b111, 1'b1, 2'd3, 0, "re_run");
      wait_to(b3 + 8);
      bus_a.soft_rst = 1'b1;
      @(negedge clk);
      bus_a.soft_rst = 1'b0;
      wait_to(b3 + 18);

      // Short rst glitch between edges 10 and 11: asynchronous clear.
      power_on(b4);
      exp_a(b4 + 9,  3'b011, 1'b0, 2'd2, 0, "pre_glitch");
      exp_a(b4 + 10, 3'b000, 1'b0, 2'd0, 0, "async_clear");
      wait_to(b4 + 9);
      @(posedge clk);
      #2 rst = 1'b0;
      #2 rst = 1'b1;
      b5 = b4 + 10;
      exp_a(b5 + 2,  3'b000, 1'b0, 2'd0, 0, "g_sync_wait");
      exp_a(b5 + 3,  3'b000, 1'b0, 2'd1, 0, "g_hold");
      exp_a(b5 + 7,  3'b001, 1'b0, 2'd2, 0, "g_rel_d0");
      exp_a(b5 + 9,  3'b011, 1'b0, 2'd2, 0, "g_rel_d1");
      exp_a(b5 + 11, 3'b111, 1'b1, 2'd3, 0, "g_run");
      exp_a(b5 + 12, 3'b111, 1'b1, 2'd3, 1, "g_run_1");

      // soft_rst held high for 10 edges from RUN pins the FSM in HOLD.
      exp_a(b5 + 13, 3'b000, 1'b0, 2'd1, 0, "pin_start");
      exp_a(b5 + 17, 3'b000, 1'b0, 2'd1, 0, "pin_mid");
      exp_a(b5 + 22, 3'b000, 1'b0, 2'd1, 0, "pin_last");
      exp_a(b5 + 25, 3'b000, 1'b0, 2'd1, 0, "pin_after");
      exp_a(b5 + 26, 3'b001, 1'b0, 2'd2, 0, "pin_rel_d0");
      exp_a(b5 + 30, 3'b111, 1'b1, 2'd3, 0, "pin_run");
      wait_to(b5 + 12);
      bus_a.soft_rst = 1'b1;
      repeat (10) @(negedge clk);
      bus_a.soft_rst = 1'b0;
      wait_to(b5 + 31);

      // Drain with a bound; anything left over is a failure.
      for (int i = 0; i < 50; i++) begin
         if (q_a.size() == 0 && q_b.size() == 0) break;
         @(negedge clk);
      end
      #1;
      if (q_a.size() != 0 || q_b.size() != 0) begin
         errors++;
         $display("FAIL drain pending a=%0d b=%0d want a=0 b=0", q_a.size(), q_b.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Parametrised power-on and soft reset controller for the MIPS processor top level. It takes the board reset and synchronises its deassertion. It then holds reset for a programmable number of cycles and releases up to NUM_DOMAINS downstream reset domains in a fixed order, e.g. memories, register file, then core. After the last release it raises `ready` and counts run cycles. It replaces hand-timed clock/reset stimulus with a synthesizable, self-checking sequence.

## Interface
- NUM_DOMAINS, 3, number of reset domains released; must be >= 1
- HOLD_CYCLES, 4, cycles spent in HOLD before the first release; must be >= 1
- STAGE_GAP, 2, cycles between consecutive domain releases; must be >= 1
- SYNC_STAGES, 2, synchroniser depth on `rst` deassertion; must be >= 2
- CNT_W, 32, width of `run_cycles`
- clk  in  1  single clock, rising-edge
- rst  in  1  reset, asynchronous, active-low
- soft_rst  in  1  synchronous request, active-high, sampled each rising edge
- domain_rst_n  out  NUM_DOMAINS  per-domain reset, active-low; bit 0 is released first
- ready  out  1  high in RUN only
- run_cycles  out  CNT_W  rising edges spent in RUN; saturates at all-ones
- state  out  2  FSM state: ASSERT=0, HOLD=1, RELEASE=2, RUN=3

## Operation
- `rst` low has these effects, asynchronously:
  - state=ASSERT, domain_rst_n=0, ready=0, run_cycles=0.
  - The synchroniser chain, hold counter and gap counter are cleared.
  - This overrides everything.
- Deassertion of `rst` propagates through a SYNC_STAGES flop chain fed with 1. The chain output is `rst_sync`.
- ASSERT -> HOLD on the edge where `rst_sync`=1. The hold counter is set to 0.
- In HOLD, on each edge:
  - If count == HOLD_CYCLES-1: leave HOLD and set domain_rst_n[0]=1 on the same edge.
  - Otherwise, increment the count.
- Destination on leaving HOLD: RELEASE if NUM_DOMAINS > 1; otherwise RUN, with ready=1 on that same edge.
- In RELEASE, the gap counter counts to STAGE_GAP-1, then releases the next domain and resets to 0. Domain i therefore releases STAGE_GAP*i edges after domain 0.
- The edge that releases domain NUM_DOMAINS-1 enters RUN and sets ready=1.
- Once released, a domain stays high until `rst` or `soft_rst`. There is never a gap in the release order.
- In RUN, run_cycles increments each edge and saturates at 2^CNT_W-1. No wrap is allowed.
- soft_rst=1 on an edge in HOLD, RELEASE or RUN has these effects:
  - domain_rst_n=0, ready=0, run_cycles=0.
  - state=HOLD, hold count=0, gap count=0.
  - soft_rst is ignored in ASSERT.
  - Holding soft_rst high pins the FSM in HOLD with count 0.
- soft_rst on the same edge as a scheduled release: soft_rst wins and no domain is released.

## Timing
- All outputs are registered. No combinational path from input to output.
- Edges below are counted from the first rising edge after `rst` rises, which is edge 1.
- Sequence with defaults:
  - `rst_sync`=1 after edge 2.
  - Edge 3: HOLD.
  - Edge 7: RELEASE, domain_rst_n=3'b001.
  - Edge 9: 3'b011.
  - Edge 11: 3'b111, RUN, ready=1.
  - Edge 12: run_cycles=1.
- General latency from the first edge to `ready` = SYNC_STAGES + 1 + HOLD_CYCLES + STAGE_GAP*(NUM_DOMAINS-1) edges.
- After soft_rst at edge S, domain 0 is released at edge S+HOLD_CYCLES.
- `rst` assertion mid-RELEASE or mid-RUN takes effect with no clock edge. A glitch shorter than one cycle still yields the full sequence.

## Structure
- Package `reset_seq_pkg`: state encoding constants (ASSERT/HOLD/RELEASE/RUN) and the 2-bit state type.
- Sub-module `reset_sync`: SYNC_STAGES-deep async-assert / sync-deassert chain, parameter SYNC_STAGES.
- Widths: hold counter $clog2(HOLD_CYCLES+1), gap counter $clog2(STAGE_GAP+1), domain index $clog2(NUM_DOMAINS+1).

## Test plan
- Defaults. rst low 2 cycles, then high -> domain_rst_n 000/001/011/111 after edges 7/9/11, ready at edge 11, run_cycles=5 after edge 16.
- soft_rst pulse at edge 20 (RUN) -> outputs 000, ready 0, run_cycles 0 after edge 20; 001 after edge 24, 111 after edge 28.
- soft_rst on edge 9 (same edge as domain 1 release) -> domain_rst_n=000 after edge 9, no 011 seen; domain 0 re-released at edge 13.
- rst pulled low mid-cycle between edges 10 and 11 -> domain_rst_n=000, state=0, run_cycles=0 immediately, before any edge; full sequence repeats after release.
- NUM_DOMAINS=1, HOLD_CYCLES=1, CNT_W=3 -> HOLD to RUN with ready on edge 4, run_cycles saturates at 7 and stays 7.
- soft_rst held high 10 cycles from RUN -> state stays HOLD, domain_rst_n=0; first release HOLD_CYCLES edges after soft_rst falls.
